// File: rtl/addsub_bist_ctrl.sv
// addsub_bist_ctrl: LFSR-driven self-test initiator for the add/sub block; ADDSUB_BIST_FIRST_FAIL_EN adds first-fail capture
module addsub_bist_ctrl #(
  parameter int WIDTH = 15,
  parameter int NUM_VECTORS = 256,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      fail_count,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_sub,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_c,
  input  logic             dut_v,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic             err_sub,
  output logic             err_valid
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [31:0] SEED_L = SEED == 32'd0 ? 32'd1 : SEED;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] q;
  logic [15:0] vcnt, fails;
  logic [SW-1:0] settle;
  logic armed, go, last, settled, mism, ce, ve;
  logic [WIDTH-1:0] bx, se;
  assign dut_a = q[WIDTH-1:0];
  assign dut_b = q[2*WIDTH-1:WIDTH];
  assign dut_sub = q[31];
  assign bx = dut_sub ? ~dut_b : dut_b;
  assign {ce, se} = {1'b0, dut_a} + {1'b0, bx} + (WIDTH+1)'(dut_sub);
  assign ve = (dut_a[WIDTH-1] == bx[WIDTH-1]) && (se[WIDTH-1] != dut_a[WIDTH-1]);
  assign mism = {dut_c, dut_v, dut_s} != {ce, ve, se};
  // armed keeps a start sampled on the reset-release edge from launching a run
  assign go = start && armed && (state == IDLE || state == DONE);
  assign last = vcnt == 16'(NUM_VECTORS - 1);
  assign settled = settle == SW'(SETTLE_CYCLES - 1);
  assign busy = state == APPLY || state == CHECK;
  assign done = state == DONE;
  assign pass = done && fails == 16'd0;
  assign fail_count = fails;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = go ? APPLY :
               (state == APPLY && settled) ? CHECK :
               state == CHECK ? (last ? DONE : APPLY) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      vcnt <= '0;
      fails <= '0;
      settle <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (go) begin
        q <= SEED_L;
        vcnt <= '0;
        fails <= '0;
        settle <= '0;
      end else if (state == APPLY) begin
        settle <= settled ? '0 : settle + 1'b1;
      end else if (state == CHECK) begin
        if (mism && fails != 16'hFFFF) fails <= fails + 1'b1;
        if (!last) begin
          q <= {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
          vcnt <= vcnt + 1'b1;
        end
      end
    end
  end
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_a <= '0;
      err_b <= '0;
      err_sub <= 1'b0;
      err_valid <= 1'b0;
    end else if (go) begin
      err_a <= '0;
      err_b <= '0;
      err_sub <= 1'b0;
      err_valid <= 1'b0;
    end else if (state == CHECK && mism && !err_valid) begin
      err_a <= dut_a;
      err_b <= dut_b;
      err_sub <= dut_sub;
      err_valid <= 1'b1;
    end
  end
`else
  assign err_a = '0;
  assign err_b = '0;
  assign err_sub = 1'b0;
  assign err_valid = 1'b0;
`endif
endmodule

// File: tb/tb_addsub_bist_ctrl.sv
// tb_addsub_bist_ctrl: scoreboard bench; three single-vector BISTs on a good adder, one 256-vector BIST on an adder with S0 stuck at 0
module tb_addsub_bist_ctrl;
  localparam logic [127:0] SEEDS = {32'hACE1_2468, 32'h81F4_03E8, 32'h0FA0_2328, 32'h0001_0010};
  typedef struct {
    logic [14:0] a, b;
    logic sub, chk_scv;
    logic [14:0] s;
    logic c, v, pass;
    logic [15:0] fc;
    int done_cyc, busy_cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, rst3_n, start_a, start3;
  logic busy_w[4], done_w[4], pass_w[4], sub_w[4], c_w[4], v_w[4], ev_w[4], es_w[4];
  logic [15:0] fc_w[4];
  logic [14:0] a_w[4], b_w[4], s_w[4], ea_w[4], eb_w[4];
  exp_t sbq[4][$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int bcnt[4] = '{default: 0};
  logic done_q[4] = '{default: 1'b0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [16:0] addm(input logic [14:0] a, input logic [14:0] b, input logic sub);
    int sa, sb, r;
    logic c;
    sa = a[14] ? int'(a) - 32768 : int'(a);
    sb = b[14] ? int'(b) - 32768 : int'(b);
    r = sub ? sa - sb : sa + sb;
    c = sub ? (a >= b) : (int'(a) + int'(b) > 32767);
    return {c, (r > 16383 || r < -16384), r[14:0]};
  endfunction
  function automatic logic [31:0] nx(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [16:0] r;
    addsub_bist_ctrl #(
      .WIDTH(15), .NUM_VECTORS(g == 3 ? 256 : 1), .SETTLE_CYCLES(1), .SEED(SEEDS[32*g +: 32])
    ) u_dut (
      .clk(clk), .rst_n(g == 3 ? rst3_n : rst_n), .start(g == 3 ? start3 : start_a),
      .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]), .fail_count(fc_w[g]),
      .dut_a(a_w[g]), .dut_b(b_w[g]), .dut_sub(sub_w[g]),
      .dut_s(s_w[g]), .dut_c(c_w[g]), .dut_v(v_w[g]),
      .err_a(ea_w[g]), .err_b(eb_w[g]), .err_sub(es_w[g]), .err_valid(ev_w[g])
    );
    assign r = addm(a_w[g], b_w[g], sub_w[g]);
    assign {c_w[g], v_w[g], s_w[g]} = g == 3 ? (r & ~17'h1) : r;
  end
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (done_w[i] === 1'b1 && !done_q[i]) begin
        if (sbq[i].size() == 0) chk($sformatf("unexpected_done%0d", i), done_w[i], 0);
        else begin
          e = sbq[i].pop_front();
          chk($sformatf("done_cycle%0d", i), cyc, e.done_cyc);
          chk($sformatf("busy_cycles%0d", i), bcnt[i], e.busy_cyc);
          chk($sformatf("vector%0d", i), {a_w[i], b_w[i], sub_w[i]}, {e.a, e.b, e.sub});
          if (e.chk_scv) chk($sformatf("scv%0d", i), {s_w[i], c_w[i], v_w[i]}, {e.s, e.c, e.v});
          chk($sformatf("pass%0d", i), pass_w[i], e.pass);
          chk($sformatf("fail_count%0d", i), fc_w[i], e.fc);
        end
      end
      done_q[i] = done_w[i] === 1'b1;
      bcnt[i] = busy_w[i] === 1'b1 ? bcnt[i] + 1 : 0;
    end
  end
  task automatic chk_zero(input int i, input string nm);
    chk($sformatf("%s_ctl%0d", nm, i), {busy_w[i], done_w[i], pass_w[i], sub_w[i], ev_w[i], es_w[i], fc_w[i]}, 0);
    chk($sformatf("%s_ops%0d", nm, i), {a_w[i], b_w[i], ea_w[i], eb_w[i]}, 0);
  endtask
  task automatic wait_empty(input int i, input int bound);
    for (int k = 0; k < bound && sbq[i].size() != 0; k++) @(negedge clk);
    chk($sformatf("timeout%0d", i), sbq[i].size(), 0);
    sbq[i].delete();
  endtask
  task automatic push_long(input logic [31:0] seed, output logic [31:0] first, output int cnt);
    logic [31:0] q, last;
    bit have;
    q = seed;
    cnt = 0;
    have = 0;
    first = '0;
    last = '0;
    // with S0 stuck at 0, a vector fails exactly when its true S0 (= A0 ^ B0) is 1
    for (int k = 0; k < 256; k++) begin
      if (q[0] ^ q[15]) begin
        cnt++;
        if (!have) first = q;
        have = 1;
      end
      last = q;
      if (k < 255) q = nx(q);
    end
    sbq[3].push_back('{a: last[14:0], b: last[29:15], sub: last[31], chk_scv: 1'b0, s: 15'd0, c: 1'b0,
                       v: 1'b0, pass: 1'b0, fc: cnt[15:0], done_cyc: cyc + 1 + 512, busy_cyc: 512});
  endtask
  initial begin
    logic [31:0] s3, first;
    int cnt;
    s3 = SEEDS[127:96];
    rst_n = 1'b0;
    rst3_n = 1'b0;
    start_a = 1'b0;
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_zero(i, "reset");
    start_a = 1'b1;
    rst_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_at_release", busy_w[0], 0);
    @(negedge clk);
    sbq[0].push_back('{a: 15'd16, b: 15'd2, sub: 1'b0, chk_scv: 1'b1, s: 15'd18, c: 1'b0, v: 1'b0,
                       pass: 1'b1, fc: 16'd0, done_cyc: cyc + 3, busy_cyc: 2});
    sbq[1].push_back('{a: 15'd9000, b: 15'd8000, sub: 1'b0, chk_scv: 1'b1, s: 15'd17000, c: 1'b0, v: 1'b1,
                       pass: 1'b1, fc: 16'd0, done_cyc: cyc + 3, busy_cyc: 2});
    sbq[2].push_back('{a: 15'd1000, b: 15'd1000, sub: 1'b1, chk_scv: 1'b1, s: 15'd0, c: 1'b1, v: 1'b0,
                       pass: 1'b1, fc: 16'd0, done_cyc: cyc + 3, busy_cyc: 2});
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) wait_empty(i, 20);
    push_long(s3, first, cnt);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (49) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_empty(3, 600);
    chk("fail_nonzero", fc_w[3] != 16'd0, 1);
`ifdef ADDSUB_BIST_FIRST_FAIL_EN
    chk("first_fail", {ev_w[3], ea_w[3], eb_w[3], es_w[3]}, {1'b1, first[14:0], first[29:15], first[31]});
`else
    chk("err_tied", {ev_w[3], ea_w[3], eb_w[3], es_w[3]}, 0);
`endif
    push_long(s3, first, cnt);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst3_n = 1'b0;
    #1 chk_zero(3, "midrun_reset");
    sbq[3].delete();
    @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    push_long(s3, first, cnt);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("restart_vector0", {a_w[3], b_w[3], sub_w[3]}, {s3[14:0], s3[29:15], s3[31]});
    wait_empty(3, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addsub_bist_ctrl.md
Name: addsub_bist_ctrl

Overview:
- Sequential built-in self-test initiator for the combinational two's-complement adder/subtractor: the `A`/`B`/`C0`-in, `S`/`C`/`V`-out block used throughout the lab.
- Generates operand vectors and drives them onto the adder's inputs, waits for the outputs to settle, then samples `S`/`C`/`V`.
- Compares each sample against an internal golden model and reports the pass/fail count.
- Sits beside the adder instance and replaces the manual testbench stimulus in the hardware build.

Parameters:
- `WIDTH`, 15, operand/sum width in bits; legal range 2..15.
- `NUM_VECTORS`, 256, vectors applied per run; legal range 1..65535.
- `SETTLE_CYCLES`, 1, clock cycles each vector is held before the compare; minimum 1.
- `SEED`, 32'h0000_0001, LFSR load value at `start`; 0 is replaced by 1.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a run when idle
- `busy`  out  1  high while a run is in progress
- `done`  out  1  high from run completion until the next `start`
- `pass`  out  1  valid with `done`; 1 if `fail_count`==0
- `fail_count`  out  16  number of mismatching vectors; saturates at 16'hFFFF
- `dut_a`  out  WIDTH  operand A to the adder (`A0`..`A[WIDTH-1]`)
- `dut_b`  out  WIDTH  operand B to the adder
- `dut_sub`  out  1  mode to the adder `C0`: 0 = add, 1 = subtract
- `dut_s`  in  WIDTH  adder sum `S`
- `dut_c`  in  1  adder carry out `C`
- `dut_v`  in  1  adder overflow `V`
- `err_a`, `err_b`  out  WIDTH  first failing operands (optional feature)
- `err_sub`  out  1  first failing mode (optional feature)
- `err_valid`  out  1  first-fail capture holds data (optional feature)

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - Every register clears; FSM returns to IDLE.
  - `busy`, `done`, `pass`, `fail_count`, `dut_a`, `dut_b`, `dut_sub` and all `err_*` outputs are 0.
  - Reset mid-run aborts the run immediately; no partial result is retained.
- LFSR: 32-bit Fibonacci.
  - Each step: q <= {q[30:0], q[31]^q[21]^q[1]^q[0]}.
  - Vector mapping: A=q[WIDTH-1:0], B=q[2*WIDTH-1:WIDTH], sub=q[31].
  - The first vector is the `SEED` value itself.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - On `start`: load the LFSR, clear `fail_count` and the vector counter.
  - Drive vector 0 onto `dut_*` on that edge; set `busy`=1 and `done`=0; go to APPLY.
- APPLY:
  - Hold `dut_*` stable for `SETTLE_CYCLES` cycles using a settle counter, then go to CHECK.
- CHECK (1 cycle):
  - Sample `dut_s`/`dut_c`/`dut_v` and compare with the golden values.
  - On any bit mismatch, increment `fail_count` (saturating).
  - If the vector counter equals `NUM_VECTORS`-1: go to DONE.
  - Otherwise: step the LFSR, drive the next vector on the same edge, increment the counter, go to APPLY.
- DONE:
  - `busy`=0, `done`=1, `pass` = (`fail_count`==0).
  - `dut_*` keep the last vector.
  - A `start` pulse re-enters the IDLE `start` action directly.
- Timing: each vector occupies `SETTLE_CYCLES`+1 cycles. `done` rises (`SETTLE_CYCLES`+1)·`NUM_VECTORS`+1 edges after the `start` edge.
- Golden model, using a (WIDTH+1)-bit sum:
  - Bx = `dut_sub` ? ~B : B.
  - {Ce, Se} = A + Bx + `dut_sub`.
  - Ve = (A[msb]==Bx[msb]) && (Se[msb]!=A[msb]).
  - Subtraction with B=0 therefore expects Ce=1.
- `start` while `busy`=1 is ignored.
- `start` coincident with reset release is ignored.

Optional Feature:
- Macro: `ADDSUB_BIST_FIRST_FAIL_EN`.
- Defined:
  - On the first mismatch of a run, capture A/B/sub into `err_a`/`err_b`/`err_sub` and set `err_valid`=1.
  - Later mismatches do not overwrite the capture.
  - All four outputs clear on `start`.
- Undefined: `err_*` outputs are tied to 0 and the capture registers are not built.

Test Plan:
- `SEED`=32'h0001_0010, `NUM_VECTORS`=1, golden adder connected -> `dut_a`=16, `dut_b`=2, `dut_sub`=0; S=18, C=0, V=0; `done`=1 after 3 edges; `pass`=1, `fail_count`=0.
- `SEED`=32'h0FA0_2328, `NUM_VECTORS`=1 -> A=9000, B=8000, add; expected S=17000 (-15768 signed), V=1, C=0; `pass`=1.
- `SEED`=32'h81F4_03E8, `NUM_VECTORS`=1 -> A=B=1000, sub; expected S=0, C=1, V=0; `pass`=1.
- `NUM_VECTORS`=256 with a fault-injected adder (`S0` stuck at 0) -> `busy` high for 512 cycles; `fail_count` equals the number of vectors whose expected S[0]=1, counted by the bench model and nonzero; `pass`=0.
  - With `ADDSUB_BIST_FIRST_FAIL_EN`: `err_valid`=1 and `err_a`/`err_b`/`err_sub` equal the first such vector.
- Mid-run: `rst_n` low at cycle 100 of a 256-vector run -> all outputs 0 asynchronously; FSM in IDLE.
  - A fresh `start` reproduces an identical vector sequence from `SEED`.
- `start` pulsed at cycle 50 of a run -> ignored; total run length and `fail_count` unchanged.
